// File: rtl/cmd_frame_decoder.sv
// Byte-stream command decoder: 'W' addr 0x4h 0x4l writes a register, 'T' fires a trigger.
// Consumes bytes from an upstream holding register and enforces an inter-byte timeout.
module cmd_frame_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] CurrentData,
    input  logic       DataAvailable,
    output logic       ClearData,
    output logic [7:0] RegAddr,
    output logic [7:0] RegData,
    output logic       RegWrite,
    output logic       Trigger,
    output logic       FrameError,
    output logic       Busy
);

    localparam int unsigned CntWidth = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StGetAddr,
        StGetDhi,
        StGetDlo
    } StateType;

    StateType            state;
    logic [CntWidth-1:0] timeoutCnt;
    logic [7:0]          pendAddr;
    logic [3:0]          dataHi;
    logic                accept;
    logic                nibbleOk;

    // While ClearData is high the upstream register still shows the byte just consumed.
    assign accept   = DataAvailable && !ClearData;
    assign nibbleOk = (CurrentData[7:4] == 4'h4);
    assign Busy     = (state != StIdle);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= StIdle;
            timeoutCnt <= '0;
            pendAddr   <= 8'h00;
            dataHi     <= 4'h0;
            ClearData  <= 1'b0;
            RegAddr    <= 8'h00;
            RegData    <= 8'h00;
            RegWrite   <= 1'b0;
            Trigger    <= 1'b0;
            FrameError <= 1'b0;
        end else begin
            ClearData <= 1'b0;
            RegWrite  <= 1'b0;
            Trigger   <= 1'b0;
            if (accept) begin
                ClearData  <= 1'b1;
                timeoutCnt <= '0;
                unique case (state)
                    StIdle: begin
                        if (CurrentData == 8'h57) begin
                            state <= StGetAddr;
                        end else if (CurrentData == 8'h54) begin
                            Trigger <= 1'b1;
                        end else begin
                            FrameError <= 1'b1;
                        end
                    end
                    StGetAddr: begin
                        pendAddr <= CurrentData;
                        state    <= StGetDhi;
                    end
                    StGetDhi: begin
                        if (nibbleOk) begin
                            dataHi <= CurrentData[3:0];
                            state  <= StGetDlo;
                        end else begin
                            FrameError <= 1'b1;
                            state      <= StIdle;
                        end
                    end
                    StGetDlo: begin
                        if (nibbleOk) begin
                            RegAddr    <= pendAddr;
                            RegData    <= {dataHi, CurrentData[3:0]};
                            RegWrite   <= 1'b1;
                            FrameError <= 1'b0;
                        end else begin
                            FrameError <= 1'b1;
                        end
                        state <= StIdle;
                    end
                    default: state <= StIdle;
                endcase
            end else if (state != StIdle) begin
                // Expiry returns to idle and restarts the counter, so it never wraps.
                if (timeoutCnt == CntLast) begin
                    FrameError <= 1'b1;
                    state      <= StIdle;
                    timeoutCnt <= '0;
                end else begin
                    timeoutCnt <= timeoutCnt + CntWidth'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_cmd_frame_decoder.sv
// Directed bench for cmd_frame_decoder with a small upstream holding-register emulation.
module tb_cmd_frame_decoder;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [7:0] CurrentData;
    logic       DataAvailable;
    logic       ClearData;
    logic [7:0] RegAddr;
    logic [7:0] RegData;
    logic       RegWrite;
    logic       Trigger;
    logic       FrameError;
    logic       Busy;

    int vectors     = 0;
    int miscompares = 0;

    int clrCount  = 0;
    int rwCount   = 0;
    int trigCount = 0;
    int dblCount  = 0;
    logic prevClr = 1'b0, prevRw = 1'b0, prevTrig = 1'b0;

    logic seenTrig, seenRw, seenBusy;

    cmd_frame_decoder #(.TIMEOUT_CYCLES(16)) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .CurrentData   (CurrentData),
        .DataAvailable (DataAvailable),
        .ClearData     (ClearData),
        .RegAddr       (RegAddr),
        .RegData       (RegData),
        .RegWrite      (RegWrite),
        .Trigger       (Trigger),
        .FrameError    (FrameError),
        .Busy          (Busy)
    );

    always #5 Clock = ~Clock;

    // Pulse counting and back-to-back detection, sampled mid-cycle.
    always @(negedge Clock) begin
        if (ClearData === 1'b1) clrCount++;
        if (RegWrite === 1'b1) rwCount++;
        if (Trigger === 1'b1) trigCount++;
        if ((ClearData === 1'b1 && prevClr) || (RegWrite === 1'b1 && prevRw) ||
            (Trigger === 1'b1 && prevTrig)) dblCount++;
        prevClr  = (ClearData === 1'b1);
        prevRw   = (RegWrite === 1'b1);
        prevTrig = (Trigger === 1'b1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed still running expected finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic present(input logic [7:0] b);
        CurrentData   = b;
        DataAvailable = 1'b1;
    endtask

    // Waits for ClearData, records the pulses coincident with it, then empties the register.
    task automatic waitConsume();
        bit found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge Clock);
            if (ClearData === 1'b1) begin
                found    = 1;
                seenTrig = Trigger;
                seenRw   = RegWrite;
                seenBusy = Busy;
            end
        end
        check("consume_timeout", 16'(found), 16'd1);
        @(posedge Clock);
        #1;
        CurrentData   = 8'h00;
        DataAvailable = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b);
        @(posedge Clock);
        #1;
        present(b);
        waitConsume();
    endtask

    initial begin
        int baseClr, baseRw, baseTrig;

        // Reset with a byte already waiting upstream.
        Reset = 1'b1;
        present(8'h54);
        repeat (3) @(negedge Clock);
        check("rst_clear", 16'(ClearData), 16'd0);
        check("rst_busy", 16'(Busy), 16'd0);
        check("rst_addr", 16'(RegAddr), 16'h00);
        check("rst_data", 16'(RegData), 16'h00);
        check("rst_ferr", 16'(FrameError), 16'd0);
        check("rst_rw_trig", {14'd0, RegWrite, Trigger}, 16'd0);
        check("rst_no_clear_count", 16'(clrCount), 16'd0);
        @(posedge Clock);
        #1 Reset = 1'b0;
        waitConsume();
        check("held_byte_trig", 16'(seenTrig), 16'd1);
        check("held_byte_busy", 16'(seenBusy), 16'd0);
        check("held_byte_trig_cnt", 16'(trigCount), 16'd1);
        check("held_byte_clr_cnt", 16'(clrCount), 16'd1);

        // Valid write frame.
        baseClr = clrCount;
        baseRw  = rwCount;
        sendByte(8'h57);
        check("wr_busy_mid", 16'(Busy), 16'd1);
        sendByte(8'h12);
        sendByte(8'h4A);
        sendByte(8'h4F);
        check("wr_rw_with_clear", 16'(seenRw), 16'd1);
        check("wr_rw_cnt", 16'(rwCount - baseRw), 16'd1);
        check("wr_clr_cnt", 16'(clrCount - baseClr), 16'd4);
        check("wr_addr", 16'(RegAddr), 16'h12);
        check("wr_data", 16'(RegData), 16'hAF);
        check("wr_ferr", 16'(FrameError), 16'd0);
        check("wr_busy_end", 16'(Busy), 16'd0);

        // Bad opcode in idle.
        baseRw = rwCount;
        sendByte(8'h20);
        check("badop_ferr", 16'(FrameError), 16'd1);
        check("badop_rw_cnt", 16'(rwCount - baseRw), 16'd0);

        // Bad data nibble aborts the frame.
        sendByte(8'h57);
        sendByte(8'h33);
        sendByte(8'h3A);
        check("badnib_ferr", 16'(FrameError), 16'd1);
        check("badnib_busy", 16'(Busy), 16'd0);
        check("badnib_addr", 16'(RegAddr), 16'h12);
        check("badnib_data", 16'(RegData), 16'hAF);
        check("badnib_rw_cnt", 16'(rwCount - baseRw), 16'd0);

        // A following valid frame clears the error.
        sendByte(8'h57);
        sendByte(8'h34);
        sendByte(8'h41);
        sendByte(8'h42);
        check("recover_ferr", 16'(FrameError), 16'd0);
        check("recover_addr", 16'(RegAddr), 16'h34);
        check("recover_data", 16'(RegData), 16'h12);

        // Timeout: expiry lands 16 cycles after the accepting edge of 0x05.
        sendByte(8'h57);
        sendByte(8'h05);
        repeat (14) @(posedge Clock);
        #1;
        check("to_pre_ferr", 16'(FrameError), 16'd0);
        check("to_pre_busy", 16'(Busy), 16'd1);
        @(posedge Clock);
        #1;
        check("to_ferr", 16'(FrameError), 16'd1);
        check("to_busy", 16'(Busy), 16'd0);

        // Byte accepted on the expiry edge keeps the frame alive.
        sendByte(8'h57);
        sendByte(8'h05);
        repeat (14) @(posedge Clock);
        #1;
        present(8'h4B);
        waitConsume();
        check("to_race_busy", 16'(Busy), 16'd1);
        sendByte(8'h4C);
        check("to_race_rw", 16'(seenRw), 16'd1);
        check("to_race_addr", 16'(RegAddr), 16'h05);
        check("to_race_data", 16'(RegData), 16'hBC);
        check("to_race_ferr", 16'(FrameError), 16'd0);

        // Reset in the middle of a frame.
        sendByte(8'h57);
        sendByte(8'h12);
        @(posedge Clock);
        #1 Reset = 1'b1;
        repeat (2) @(negedge Clock);
        check("midrst_busy", 16'(Busy), 16'd0);
        check("midrst_addr", 16'(RegAddr), 16'h00);
        check("midrst_data", 16'(RegData), 16'h00);
        check("midrst_ferr", 16'(FrameError), 16'd0);
        check("midrst_pulses", {13'd0, ClearData, RegWrite, Trigger}, 16'd0);
        @(posedge Clock);
        #1 Reset = 1'b0;
        baseRw = rwCount;
        sendByte(8'h4A);
        check("midrst_opcode_ferr", 16'(FrameError), 16'd1);
        check("midrst_opcode_busy", 16'(Busy), 16'd0);
        check("midrst_opcode_rw", 16'(rwCount - baseRw), 16'd0);

        // Consume guard: byte stays visible through the ClearData cycle.
        baseClr  = clrCount;
        baseTrig = trigCount;
        sendByte(8'h54);
        repeat (3) @(posedge Clock);
        #1;
        check("guard_clr_cnt", 16'(clrCount - baseClr), 16'd1);
        check("guard_trig_cnt", 16'(trigCount - baseTrig), 16'd1);
        check("guard_trig_with_clear", 16'(seenTrig), 16'd1);
        check("no_back_to_back", 16'(dblCount), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
